// File: rtl/sid_dac_sequencer.sv
// Paces the two SID voice-mix samples into a pair of MCP4921 DACs that share SCK/CS/LDAC.
// Frame = 35*CLK_DIV cycles. A tick that arrives mid-frame is dropped and flagged as overrun; there is no input backpressure.
module sid_dac_sequencer #(
    parameter int         CLK_DIV    = 4,
    parameter int         SAMPLE_DIV = 256,
    parameter logic [3:0] CFG_NIBBLE = 4'b0011,
    parameter bit         INVERT     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] sample_1,
    input  logic [11:0] sample_2,
    output logic        sample_strobe,
    output logic        dac_clk,
    output logic        dac_dat_1,
    output logic        dac_dat_2,
    output logic        dac_cs_b,
    output logic        dac_le_b,
    output logic        busy,
    output logic        overrun
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("sid_dac_sequencer: CLK_DIV must be >= 1");
    end
    if (SAMPLE_DIV < 35 * CLK_DIV + 1) begin : g_bad_sample_div
        $error("sid_dac_sequencer: SAMPLE_DIV must be >= 35*CLK_DIV+1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CSH,
        ST_LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic            hi_q, hi_d;
    logic [3:0]      bit_q, bit_d;
    logic [15:0]     sr1_q, sr1_d;
    logic [15:0]     sr2_q, sr2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovr_q, ovr_d;
    logic            strobe_q, strobe_d;
    logic            cs_b_q, cs_b_d;
    logic            le_b_q, le_b_d;
    logic            tick;
    logic            ph_last;

    assign tick    = enable && (cnt_q == '0);
    assign ph_last = (ph_q == PW'(CLK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_last ? '0 : ph_q + PW'(1);
        hi_d     = hi_q;
        bit_d    = bit_q;
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;
        strobe_d = 1'b0;
        cnt_d    = (!enable || cnt_q == CW'(SAMPLE_DIV - 1)) ? '0 : cnt_q + CW'(1);
        ovr_d    = enable && (ovr_q || (tick && state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                ph_d = '0;
                if (tick) begin
                    state_d  = ST_LOAD;
                    sr1_d    = {CFG_NIBBLE, INVERT ? ~sample_1 : sample_1};
                    sr2_d    = {CFG_NIBBLE, INVERT ? ~sample_2 : sample_2};
                    strobe_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ph_last) begin
                    state_d = ST_SHIFT;
                    hi_d    = 1'b0;
                    bit_d   = 4'd0;
                end
            end
            ST_SHIFT: begin
                // Data advances only as the high phase ends, so it is settled before each SCK rise;
                // zeros shift in, leaving SDI low once the word is out.
                if (ph_last) begin
                    if (!hi_q) begin
                        hi_d = 1'b1;
                    end else begin
                        hi_d  = 1'b0;
                        sr1_d = {sr1_q[14:0], 1'b0};
                        sr2_d = {sr2_q[14:0], 1'b0};
                        if (bit_q == 4'd15) begin
                            state_d = ST_CSH;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            ST_CSH: begin
                if (ph_last) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (ph_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        cs_b_d = !(state_d == ST_LOAD || state_d == ST_SHIFT);
        le_b_d = (state_d != ST_LATCH);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ph_q     <= '0;
            hi_q     <= 1'b0;
            bit_q    <= 4'd0;
            sr1_q    <= 16'h0000;
            sr2_q    <= 16'h0000;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            strobe_q <= 1'b0;
            cs_b_q   <= 1'b1;
            le_b_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            hi_q     <= hi_d;
            bit_q    <= bit_d;
            sr1_q    <= sr1_d;
            sr2_q    <= sr2_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            strobe_q <= strobe_d;
            cs_b_q   <= cs_b_d;
            le_b_q   <= le_b_d;
        end
    end

    assign sample_strobe = strobe_q;
    assign dac_clk       = hi_q;
    assign dac_dat_1     = sr1_q[15];
    assign dac_dat_2     = sr2_q[15];
    assign dac_cs_b      = cs_b_q;
    assign dac_le_b      = le_b_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_sid_dac_sequencer.sv
// Directed bench for sid_dac_sequencer: a default instance and an INVERT=1 instance share clock and reset.
module tb_sid_dac_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_en = 1'b0, b_en = 1'b0;
    logic [11:0] a_s1 = 12'h000, a_s2 = 12'h000, b_s1 = 12'h000, b_s2 = 12'h000;
    logic        a_stb, a_sck, a_d1, a_d2, a_cs_b, a_le_b, a_busy, a_ovr;
    logic        b_stb, b_sck, b_d1, b_d2, b_cs_b, b_le_b, b_busy, b_ovr;

    sid_dac_sequencer u_dut_a (
        .clk_i(clk), .rst_n(rst_n), .enable(a_en), .sample_1(a_s1), .sample_2(a_s2),
        .sample_strobe(a_stb), .dac_clk(a_sck), .dac_dat_1(a_d1), .dac_dat_2(a_d2),
        .dac_cs_b(a_cs_b), .dac_le_b(a_le_b), .busy(a_busy), .overrun(a_ovr)
    );

    sid_dac_sequencer #(.INVERT(1'b1)) u_dut_b (
        .clk_i(clk), .rst_n(rst_n), .enable(b_en), .sample_1(b_s1), .sample_2(b_s2),
        .sample_strobe(b_stb), .dac_clk(b_sck), .dac_dat_1(b_d1), .dac_dat_2(b_d2),
        .dac_cs_b(b_cs_b), .dac_le_b(b_le_b), .busy(b_busy), .overrun(b_ovr)
    );

    // Pin-level monitor; sel picks which instance is being observed.
    logic sel = 1'b0;
    logic m_cs, m_le, m_sck, m_d1, m_d2, m_stb;
    assign m_cs  = sel ? b_cs_b : a_cs_b;
    assign m_le  = sel ? b_le_b : a_le_b;
    assign m_sck = sel ? b_sck  : a_sck;
    assign m_d1  = sel ? b_d1   : a_d1;
    assign m_d2  = sel ? b_d2   : a_d2;
    assign m_stb = sel ? b_stb  : a_stb;

    int          cyc = 0, cs_cnt = 0, cs_len = 0, le_cnt = 0, le_len = 0;
    int          frames = 0, strobes = 0, bits = 0, last_fall = 0, prev_fall = 0;
    logic [15:0] cap1 = 16'h0, cap2 = 16'h0;
    logic        prev_cs = 1'b1, prev_le = 1'b1, prev_sck = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_cs && !m_cs) begin
            bits = 0; cap1 = 16'h0; cap2 = 16'h0; cs_cnt = 0;
            prev_fall = last_fall; last_fall = cyc;
        end
        if (!m_cs) cs_cnt++;
        if (!prev_cs && m_cs) cs_len = cs_cnt;
        if (prev_le && !m_le) le_cnt = 0;
        if (!m_le) le_cnt++;
        if (!prev_le && m_le) begin le_len = le_cnt; frames++; end
        if (m_sck && !prev_sck) begin
            cap1 = {cap1[14:0], m_d1}; cap2 = {cap2[14:0], m_d2}; bits++;
        end
        if (m_stb) strobes++;
        prev_cs = m_cs; prev_le = m_le; prev_sck = m_sck;
    end

    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cs_low();
        int i;
        for (i = 0; i < 600 && m_cs; i++) step();
        check("cs_fall_timeout", {31'd0, m_cs}, 32'd0);
    endtask

    task automatic wait_frame(input int target);
        int i;
        for (i = 0; i < 1000 && frames < target; i++) step();
        check("frame_timeout", {31'd0, (frames >= target)}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cs_b"}, {31'd0, a_cs_b}, 32'd1);
        check({pfx, "_le_b"}, {31'd0, a_le_b}, 32'd1);
        check({pfx, "_sck"},  {31'd0, a_sck},  32'd0);
        check({pfx, "_dat"},  {30'd0, a_d1, a_d2}, 32'd0);
        check({pfx, "_busy"}, {31'd0, a_busy}, 32'd0);
        check({pfx, "_ovr"},  {31'd0, a_ovr},  32'd0);
        check({pfx, "_stb"},  {31'd0, a_stb},  32'd0);
    endtask

    int s0, f0;

    initial begin
        // Reset values
        repeat (3) step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // First frame: tick on the first edge with enable high
        a_s1 = 12'hABC; a_s2 = 12'h123; a_en = 1'b1;
        step();
        check("first_strobe", {31'd0, a_stb}, 32'd1);
        check("first_cs_low", {31'd0, a_cs_b}, 32'd0);
        check("first_busy", {31'd0, a_busy}, 32'd1);
        wait_frame(1);
        check("f1_word1", {16'd0, cap1}, 32'h3ABC);
        check("f1_word2", {16'd0, cap2}, 32'h3123);
        check("f1_bits", bits, 32'd16);
        check("f1_cs_len", cs_len, 32'd132);
        check("f1_le_len", le_len, 32'd4);
        check("f1_busy_end", {31'd0, a_busy}, 32'd0);

        // Second frame: period, and a sample change mid-SHIFT
        wait_cs_low();
        check("period", last_fall - prev_fall, 32'd256);
        repeat (40) step();
        a_s1 = 12'h555;
        wait_frame(2);
        check("f2_word1_unchanged", {16'd0, cap1}, 32'h3ABC);
        wait_frame(3);
        check("f3_word1_new", {16'd0, cap1}, 32'h3555);
        check("f3_word2", {16'd0, cap2}, 32'h3123);
        check("strobes_3", strobes, 32'd3);

        // Enable dropped at the start of bit 5
        wait_cs_low();
        repeat (44) step();
        a_en = 1'b0;
        s0 = strobes;
        wait_frame(4);
        check("f4_word1_full", {16'd0, cap1}, 32'h3555);
        check("f4_le_len", le_len, 32'd4);
        repeat (600) step();
        check("idle_no_strobe", strobes, s0);
        check("idle_busy", {31'd0, a_busy}, 32'd0);
        check("idle_cs_b", {31'd0, a_cs_b}, 32'd1);

        // Early tick forced by an enable pulse while busy
        a_en = 1'b1;
        step();
        step();
        check("ovr_pre", {31'd0, a_ovr}, 32'd0);
        a_en = 1'b0;
        step();
        a_en = 1'b1;
        step();
        check("ovr_set", {31'd0, a_ovr}, 32'd1);
        check("ovr_tick_ignored", strobes, s0 + 1);
        wait_frame(5);
        check("ovr_frame_word1", {16'd0, cap1}, 32'h3555);
        check("ovr_sticky", {31'd0, a_ovr}, 32'd1);
        a_en = 1'b0;
        step();
        check("ovr_clear", {31'd0, a_ovr}, 32'd0);

        // Asynchronous reset in the SCK-high phase of bit 1
        repeat (300) step();
        a_en = 1'b1;
        wait_cs_low();
        repeat (18) step();
        check("pre_rst_sck_high", {31'd0, a_sck}, 32'd1);
        f0 = frames;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        a_en = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (300) step();
        check("abort_no_ldac", frames, f0);

        // INVERT=1 instance
        sel = 1'b1;
        b_s1 = 12'h000; b_s2 = 12'hFFF; b_en = 1'b1;
        wait_frame(f0 + 1);
        check("inv_word1", {16'd0, cap1}, 32'h3FFF);
        check("inv_word2", {16'd0, cap2}, 32'h3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
